// File: rtl/axi_read.sv
// axi_read: AXI4 read master issuing fixed-length INCR bursts at a stepping, wrapping address and streaming beats out.
module axi_read #(
    parameter int FLIP_BYTE  = 0,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int AR_LEN     = 16,
    parameter int ADDR_STEP  = 4096,
    parameter int ADDR_RANGE = 65536
) (
    input  logic                  M_RD_aclk,
    input  logic                  M_RD_aresetn,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] M_RD_tdata,
    output logic                  M_RD_tvalid,
    output logic                  M_RD_tlast,
    input  logic                  M_RD_tready,
    output logic                  rd_err,
    output logic                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(ADDR_RANGE - ADDR_STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [8:0]            LAST  = 9'(AR_LEN - 1);
    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [8:0]              cnt;
    logic [DATA_WIDTH-1:0]   flipped;
    logic                    beat;
    logic                    unused_rid;
    assign unused_rid    = m_axi_rid;
    assign m_axi_arid    = 1'b0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlen   = 8'(AR_LEN - 1);
    assign m_axi_arsize  = DATA_WIDTH == 128 ? 3'd4 : DATA_WIDTH == 64 ? 3'd3 : 3'd2;
    assign m_axi_araddr  = addr;
    assign beat          = state == RD_DATA && m_axi_rvalid && M_RD_tready;
    // Byte 0 of the AXI beat lands in the most significant byte of the stream.
    always_comb begin
        flipped = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            flipped[8*i +: 8] = m_axi_rdata[DATA_WIDTH-8-8*i +: 8];
    end
    always_ff @(posedge M_RD_aclk) begin
        if (!M_RD_aresetn) state <= RD_IDLE;
        else               state <= state_nxt;
    end
    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        M_RD_tvalid   = 1'b0;
        M_RD_tlast    = 1'b0;
        M_RD_tdata    = '0;
        m_axi_rready  = 1'b0;
        case (state)
            RD_IDLE: state_nxt = rd_en ? RD_ADDR : RD_IDLE;
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                state_nxt     = m_axi_arready ? RD_DATA : RD_ADDR;
            end
            RD_DATA: begin
                M_RD_tvalid  = m_axi_rvalid;
                M_RD_tlast   = m_axi_rlast;
                M_RD_tdata   = FLIP_BYTE != 0 ? flipped : m_axi_rdata;
                m_axi_rready = M_RD_tready;
                state_nxt    = beat && m_axi_rlast ? RD_DONE : RD_DATA;
            end
            RD_DONE: state_nxt = RD_IDLE;
        endcase
    end
    // Length errors only flag; the burst still ends solely on an accepted rlast.
    always_ff @(posedge M_RD_aclk) begin
        if (!M_RD_aresetn) begin
            addr   <= '0;
            cnt    <= '0;
            rd_err <= 1'b0;
        end else begin
            if (state == RD_ADDR) cnt <= '0;
            else if (beat)        cnt <= cnt + 9'd1;
            if (beat && (m_axi_rresp != 2'b00 || (m_axi_rlast && cnt != LAST) || (!m_axi_rlast && cnt == LAST)))
                rd_err <= 1'b1;
            if (state == RD_DONE) addr <= addr >= LIMIT ? '0 : addr + STEP;
        end
    end
endmodule

// File: tb/tb_axi_read.sv
// tb_axi_read: randomized directed bursts against an address/error/stream reference model.
module tb_axi_read;
    localparam int DW = 64, LEN = 16, STEP = 4096, RANGE = 65536;
    logic clk = 0, aresetn = 0, rd_en = 0, tready = 0, arready = 0, rid = 0, rlast = 0, rvalid = 0;
    logic [DW-1:0] rdata = '0;
    logic [1:0] rresp = '0;
    logic [DW-1:0] tdata, f_tdata;
    logic tvalid, tlast, rd_err, arid, arlock, arvalid, rready;
    logic [31:0] araddr, f_araddr;
    logic [7:0] arlen, f_arlen;
    logic [2:0] arsize, arprot, f_arsize, f_arprot;
    logic [1:0] arburst, f_arburst;
    logic [3:0] arcache, arqos, f_arcache, f_arqos;
    logic f_tvalid, f_tlast, f_rd_err, f_arid, f_arlock, f_arvalid, f_rready;
    int total = 0, bad = 0;
    logic [31:0] exp_addr = 0;
    logic exp_err = 0;
    always #5 clk = ~clk;
    axi_read dut (
        .M_RD_aclk(clk), .M_RD_aresetn(aresetn), .rd_en(rd_en), .M_RD_tdata(tdata), .M_RD_tvalid(tvalid),
        .M_RD_tlast(tlast), .M_RD_tready(tready), .rd_err(rd_err), .m_axi_arid(arid), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );
    axi_read #(.FLIP_BYTE(1)) dut_f (
        .M_RD_aclk(clk), .M_RD_aresetn(aresetn), .rd_en(rd_en), .M_RD_tdata(f_tdata), .M_RD_tvalid(f_tvalid),
        .M_RD_tlast(f_tlast), .M_RD_tready(tready), .rd_err(f_rd_err), .m_axi_arid(f_arid), .m_axi_araddr(f_araddr),
        .m_axi_arlen(f_arlen), .m_axi_arsize(f_arsize), .m_axi_arburst(f_arburst), .m_axi_arlock(f_arlock),
        .m_axi_arcache(f_arcache), .m_axi_arprot(f_arprot), .m_axi_arqos(f_arqos), .m_axi_arvalid(f_arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(f_rready)
    );
    function automatic logic [DW-1:0] rev(input logic [DW-1:0] x);
        return {<<8{x}};
    endfunction
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic reset_cycle();
        @(negedge clk);
        aresetn = 0; rvalid = 1; tready = 1; rlast = 1;
        @(negedge clk); #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_err", rd_err, 0);
        chk("rst_araddr", araddr, 0);
        aresetn = 1; rvalid = 0; rlast = 0;
        exp_addr = 0; exp_err = 0;
    endtask
    task automatic burst(input int ar_delay, input bit toggle, input bit idx_data, input int err_beat,
                         input int last_beat, input int rst_beat);
        int n, b, got;
        bit done;
        logic [DW-1:0] want;
        rd_en = 1; n = 0;
        do begin @(negedge clk); arready = 0; #1; n++; end while (arvalid !== 1 && n < 10);
        chk("arvalid_rise", arvalid, 1);
        if (arvalid !== 1) return;
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, LEN - 1);
        chk("arsize", arsize, 3);
        chk("arburst", arburst, 1);
        chk("arcache", arcache, 3);
        chk("ar_zero", {arid, arlock, arprot, arqos}, 0);
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk); #1;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, exp_addr);
        end
        arready = 1;
        @(posedge clk); #1;
        arready = 0; rd_en = 1'($urandom % 2);
        b = 0; got = 0; done = 0; n = 0;
        while (!done && n < 300) begin
            @(negedge clk); n++;
            chk("rd_err", rd_err, exp_err);
            if (n == 1) chk("arvalid_drop", arvalid, 0);
            tready = toggle ? (n % 2 == 1) : ($urandom % 4 != 0);
            rvalid = $urandom % 4 != 0;
            if (b == rst_beat) begin rvalid = 1; tready = 1; end
            if (idx_data) want = DW'(b);
            else if (b == 0) want = 64'h0102030405060708;
            else want = {$urandom, $urandom};
            rdata = want;
            rlast = b == last_beat;
            rresp = b == err_beat ? 2'b10 : 2'b00;
            #1;
            chk("tvalid", tvalid, rvalid);
            chk("rready", rready, tready);
            chk("tlast", tlast, rlast);
            chk("tdata", tdata, want);
            chk("tdata_flip", f_tdata, rev(want));
            if (b == 0 && !idx_data) chk("flip_const", f_tdata, 64'h0807060504030201);
            if (tvalid && tready) got++;
            if (rvalid && tready) begin
                if (b == rst_beat) begin
                    aresetn = 0;
                    @(negedge clk); #1;
                    chk("mid_rst_arvalid", arvalid, 0);
                    chk("mid_rst_rready", rready, 0);
                    chk("mid_rst_tvalid", tvalid, 0);
                    chk("mid_rst_err", rd_err, 0);
                    aresetn = 1; rvalid = 0; rlast = 0; rd_en = 1;
                    exp_addr = 0; exp_err = 0;
                    return;
                end
                if (rresp != 0 || rlast != (b == LEN - 1)) exp_err = 1;
                if (rlast) done = 1;
                else b++;
            end
        end
        chk("burst_end", done, 1);
        if (!done) return;
        chk("beats", got, last_beat + 1);
        rd_en = 1; rvalid = 1; tready = 1; rlast = 1;
        exp_addr = (exp_addr + STEP) % RANGE;
        repeat (2) begin
            @(negedge clk); #1;
            chk("post_tvalid", tvalid, 0);
            chk("post_rready", rready, 0);
            chk("post_tlast", tlast, 0);
            chk("post_arvalid", arvalid, 0);
            chk("post_err", rd_err, exp_err);
        end
        @(negedge clk); #1;
        chk("gap_arvalid", arvalid, 1);
        chk("next_addr", araddr, exp_addr);
        rvalid = 0; rlast = 0;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        reset_cycle();
        burst(0, 0, 1, -1, 15, -1);
        burst(5, 1, 1, -1, 15, -1);
        burst(0, 0, 0, 3, 15, 7);
        burst(2, 0, 0, -1, 15, -1);
        burst(0, 0, 0, -1, 10, -1);
        burst(1, 0, 0, -1, 15, -1);
        reset_cycle();
        for (int k = 0; k < 17; k++) burst(int'($urandom % 4), 1'($urandom % 2), 0, -1, 15, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
